// File: rtl/idu_pkg.sv
// Shared definitions for the decode/issue controller and its scoreboard.
//   - CU op codes as produced by the instruction decoder (0..40)
//   - ctrl_state_e : sequencer states
//   - NOP_INSTR    : addi x0,x0,0, driven into the decoder while idle/after reset
//   - is_drain_op  : ops that must wait for every outstanding write to retire
package idu_pkg;

    localparam logic [5:0] CU_NOP    = 6'd0,  CU_ADD    = 6'd1,  CU_SUB    = 6'd2,  CU_AND    = 6'd3;
    localparam logic [5:0] CU_OR     = 6'd4,  CU_XOR    = 6'd5,  CU_SLL    = 6'd6,  CU_SRL    = 6'd7;
    localparam logic [5:0] CU_SRA    = 6'd8,  CU_SLT    = 6'd9,  CU_SLTU   = 6'd10, CU_ADDI   = 6'd11;
    localparam logic [5:0] CU_ANDI   = 6'd12, CU_ORI    = 6'd13, CU_XORI   = 6'd14, CU_SLLI   = 6'd15;
    localparam logic [5:0] CU_SRLI   = 6'd16, CU_SRAI   = 6'd17, CU_SLTI   = 6'd18, CU_SLTIU  = 6'd19;
    localparam logic [5:0] CU_LUI    = 6'd20, CU_AUIPC  = 6'd21, CU_JAL    = 6'd22, CU_JALR   = 6'd23;
    localparam logic [5:0] CU_BEQ    = 6'd24, CU_BNE    = 6'd25, CU_BLT    = 6'd26, CU_BGE    = 6'd27;
    localparam logic [5:0] CU_BLTU   = 6'd28, CU_BGEU   = 6'd29, CU_LB     = 6'd30, CU_LH     = 6'd31;
    localparam logic [5:0] CU_LW     = 6'd32, CU_LBU    = 6'd33, CU_LHU    = 6'd34, CU_SB     = 6'd35;
    localparam logic [5:0] CU_SW     = 6'd36, CU_FENCE  = 6'd37, CU_FENCE_I = 6'd38, CU_ECALL = 6'd39;
    localparam logic [5:0] CU_EBREAK = 6'd40;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        CHECK  = 3'd2,
        ISSUE  = 3'd3,
        TRAP   = 3'd4
    } ctrl_state_e;

    function automatic logic is_drain_op(input logic [5:0] op);
        return (op == CU_FENCE) || (op == CU_FENCE_I) || (op == CU_ECALL) || (op == CU_EBREAK);
    endfunction

endpackage

// File: rtl/idu_scoreboard.sv
// Register-write scoreboard: one pending bit per architectural register plus a
// count of outstanding writes, and the RAW/WAW/capacity/drain hazard compare.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   set_en, set_rd        mark rd as pending (issue handshake of a writing op)
//   wb_valid, wb_rd       retire a write (clears pending bit, decrements count)
//   use_rs1/rs1, use_rs2/rs2, wr_rd/rd, drain   operands of the held op
//   hazard                held op must not issue this cycle
//   inflight_cnt          outstanding writes
module idu_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [4:0]       set_rd,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             use_rs1,
    input  logic [4:0]       rs1,
    input  logic             use_rs2,
    input  logic [4:0]       rs2,
    input  logic             wr_rd,
    input  logic [4:0]       rd,
    input  logic             drain,
    output logic             hazard,
    output logic [CNT_W-1:0] inflight_cnt
);

    logic [31:0]      pending_reg, pending_next;
    logic [31:0]      wb_mask;
    logic [31:0]      pend_eff;
    logic [CNT_W-1:0] inflight_reg, inflight_next;
    logic             set_hit, wb_hit;

    // x0 is hard-wired: never pending, never cleared, never counted.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            if (gi == 0) begin : g_x0
                assign wb_mask[gi]      = 1'b0;
                assign pending_next[gi] = 1'b0;
            end else begin : g_xn
                assign wb_mask[gi] = wb_valid && (wb_rd == 5'(gi));
                // A same-cycle set of the register being retired wins.
                assign pending_next[gi] = (set_en && (set_rd == 5'(gi))) ? 1'b1 :
                                          (wb_mask[gi] ? 1'b0 : pending_reg[gi]);
            end
        end
    endgenerate

    // Writeback retiring this cycle is already visible to the hazard check.
    assign pend_eff = pending_reg & ~wb_mask;

    assign set_hit = set_en && (set_rd != 5'd0);
    // Only a retire of a genuinely pending register decrements, so no underflow.
    assign wb_hit  = |(pending_reg & wb_mask);

    always_comb begin
        inflight_next = inflight_reg;
        case ({set_hit, wb_hit})
            2'b10:   inflight_next = inflight_reg + CNT_W'(1);
            2'b01:   inflight_next = inflight_reg - CNT_W'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && (rs1 != 5'd0) && pend_eff[rs1])
            hazard = 1'b1;
        if (use_rs2 && (rs2 != 5'd0) && pend_eff[rs2])
            hazard = 1'b1;
        if (wr_rd && (rd != 5'd0) && pend_eff[rd])
            hazard = 1'b1;
        if (wr_rd && (rd != 5'd0) && (inflight_reg == CNT_W'(MAX_INFLIGHT)))
            hazard = 1'b1;
        if (drain && (pend_eff != 32'd0))
            hazard = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg  <= 32'd0;
            inflight_reg <= '0;
        end else begin
            pending_reg  <= pending_next;
            inflight_reg <= inflight_next;
        end
    end

    assign inflight_cnt = inflight_reg;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Sequencer around the instruction decoder: accepts a fetched word, holds it on
// dec_instr for DECODE_LAT cycles, samples the decoded fields, waits out
// register hazards against the scoreboard and issues to the CU via valid/ready.
// Illegal encodings produce a one-cycle illegal_trap instead of an issue.
// Ports:
//   soc_clk, reset_n                     clock, asynchronous active-low reset
//   fetch_valid/fetch_instr/fetch_ready  fetch handshake (ready only in IDLE)
//   dec_instr -> decoder, dec_* <- decoded fields
//   issue_valid/issue_ready/issue_cu_op/issue_rd   CU handshake
//   wb_valid/wb_rd                       register write retirement
//   flush                                discard held op, back to IDLE
//   stall, illegal_trap, inflight_cnt    status
module decode_issue_ctrl
    import idu_pkg::*;
#(
    parameter int DECODE_LAT   = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             soc_clk,
    input  logic             reset_n,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr,
    output logic             fetch_ready,
    output logic [31:0]      dec_instr,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_wr_rd,
    input  logic [5:0]       dec_cu_op,
    input  logic             dec_invalid,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [5:0]       issue_cu_op,
    output logic [4:0]       issue_rd,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic             illegal_trap,
    output logic [CNT_W-1:0] inflight_cnt
);

    localparam int LAT_W = (DECODE_LAT > 1) ? $clog2(DECODE_LAT) : 1;

    ctrl_state_e      state_reg, state_next;
    logic [31:0]      dec_instr_reg;
    logic [LAT_W-1:0] lat_cnt_reg;
    logic [5:0]       cu_op_reg;
    logic [4:0]       rd_reg, rs1_reg, rs2_reg;
    logic             use_rs1_reg, use_rs2_reg, wr_rd_reg;
    logic             lat_done, accept, sample, hazard, set_en;

    // A flush in IDLE must not start a new op in the same cycle.
    assign fetch_ready = (state_reg == IDLE) && !flush;
    assign accept      = fetch_valid && fetch_ready;
    assign lat_done    = (lat_cnt_reg == LAT_W'(DECODE_LAT - 1));
    assign sample      = (state_reg == DECODE) && lat_done;
    // Handshake completes even under a coincident flush.
    assign set_en      = (state_reg == ISSUE) && issue_ready && wr_rd_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)       state_next = DECODE;
            DECODE:  if (lat_done)     state_next = dec_invalid ? TRAP : CHECK;
            CHECK:   if (!hazard)      state_next = ISSUE;
            ISSUE:   if (issue_ready)  state_next = IDLE;
            TRAP:                      state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge soc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            dec_instr_reg <= NOP_INSTR;
            lat_cnt_reg   <= '0;
            cu_op_reg     <= 6'd0;
            rd_reg        <= 5'd0;
            rs1_reg       <= 5'd0;
            rs2_reg       <= 5'd0;
            use_rs1_reg   <= 1'b0;
            use_rs2_reg   <= 1'b0;
            wr_rd_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                dec_instr_reg <= fetch_instr;
                lat_cnt_reg   <= '0;
            end else if ((state_reg == DECODE) && !lat_done) begin
                lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
            end
            if (sample) begin
                cu_op_reg   <= dec_cu_op;
                rd_reg      <= dec_wr_rd ? dec_rd : 5'd0;
                rs1_reg     <= dec_rs1;
                rs2_reg     <= dec_rs2;
                use_rs1_reg <= dec_use_rs1;
                use_rs2_reg <= dec_use_rs2;
                wr_rd_reg   <= dec_wr_rd;
            end
        end
    end

    idu_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_scoreboard (
        .clk          (soc_clk),
        .rst_n        (reset_n),
        .set_en       (set_en),
        .set_rd       (rd_reg),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .use_rs1      (use_rs1_reg),
        .rs1          (rs1_reg),
        .use_rs2      (use_rs2_reg),
        .rs2          (rs2_reg),
        .wr_rd        (wr_rd_reg),
        .rd           (rd_reg),
        .drain        (is_drain_op(cu_op_reg)),
        .hazard       (hazard),
        .inflight_cnt (inflight_cnt)
    );

    assign dec_instr    = dec_instr_reg;
    assign issue_valid  = (state_reg == ISSUE);
    assign issue_cu_op  = cu_op_reg;
    assign issue_rd     = rd_reg;
    assign stall        = (state_reg == CHECK) && hazard;
    assign illegal_trap = (state_reg == TRAP);

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;
    import idu_pkg::*;

    logic        soc_clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] dec_instr;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_invalid;
    logic [5:0]  dec_cu_op;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_cu_op;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush, stall, illegal_trap;
    logic [2:0]  inflight_cnt;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb_q[$];   // expected {cu_op, rd} per issue handshake

    always #5 soc_clk = ~soc_clk;

    decode_issue_ctrl #(.DECODE_LAT(2), .MAX_INFLIGHT(4), .CNT_W(3)) dut (
        .soc_clk(soc_clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
        .dec_instr(dec_instr), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
        .dec_cu_op(dec_cu_op), .dec_invalid(dec_invalid),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_cu_op(issue_cu_op), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall),
        .illegal_trap(illegal_trap), .inflight_cnt(inflight_cnt)
    );

    // Minimal decoder model: addi, add, fence/fence.i, ecall/ebreak; all else illegal.
    always_comb begin
        dec_rd      = dec_instr[11:7];
        dec_rs1     = dec_instr[19:15];
        dec_rs2     = dec_instr[24:20];
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_wr_rd   = 1'b0;
        dec_cu_op   = CU_NOP;
        dec_invalid = 1'b0;
        case (dec_instr[6:0])
            7'h13: begin dec_use_rs1 = 1'b1; dec_wr_rd = 1'b1; dec_cu_op = CU_ADDI; end
            7'h33: begin dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; dec_wr_rd = 1'b1; dec_cu_op = CU_ADD; end
            7'h0F: dec_cu_op = dec_instr[12] ? CU_FENCE_I : CU_FENCE;
            7'h73: dec_cu_op = dec_instr[20] ? CU_EBREAK : CU_ECALL;
            default: dec_invalid = 1'b1;
        endcase
    end

    function automatic logic [31:0] enc_addi(input logic [4:0] rd);
        return {12'd5, 5'd0, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

    // Issue monitor: every handshake is popped from the scoreboard and compared.
    always @(negedge soc_clk) begin
        if (reset_n && issue_valid && issue_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got cu_op=%0d rd=%0d, expected no issue", issue_cu_op, issue_rd);
            end else begin
                logic [10:0] exp_v;
                exp_v = sb_q.pop_front();
                $display("issue: cu_op=%0d rd=%0d (expected cu_op=%0d rd=%0d)", issue_cu_op, issue_rd, exp_v[10:5], exp_v[4:0]);
                if ({issue_cu_op, issue_rd} !== exp_v) begin
                    errors++;
                    $display("FAIL issue_fields: got cu_op=%0d rd=%0d, expected cu_op=%0d rd=%0d",
                             issue_cu_op, issue_rd, exp_v[10:5], exp_v[4:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        int n = 0;
        fetch_instr = instr;
        fetch_valid = 1'b1;
        while (!fetch_ready && n < 50) begin tick(); n++; end
        if (!fetch_ready) begin
            checks++; errors++;
            $display("FAIL fetch_timeout: fetch_ready=%0b, expected 1", fetch_ready);
        end
        tick();
        fetch_valid = 1'b0;
        $display("fetch: instr=%08h", instr);
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
        tick();
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        $display("writeback: rd=%0d", rd);
    endtask

    task automatic wait_issued();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin tick(); n++; end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL issue_timeout: %0d ops outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!issue_valid && n < 50) begin tick(); n++; end
        if (!issue_valid) begin
            checks++; errors++;
            $display("FAIL valid_timeout: issue_valid=%0b, expected 1", issue_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_valid = 1'b0; fetch_instr = 32'd0; issue_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_fetch_ready: got %0b, expected 1", fetch_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %0b, expected 0", issue_valid); end
        checks++; if ({issue_cu_op, issue_rd} !== 11'd0) begin errors++; $display("FAIL rst_issue_fields: got %0d/%0d, expected 0/0", issue_cu_op, issue_rd); end
        checks++; if ({stall, illegal_trap} !== 2'b00) begin errors++; $display("FAIL rst_status: got stall=%0b trap=%0b, expected 0/0", stall, illegal_trap); end
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL rst_inflight: got %0d, expected 0", inflight_cnt); end
        checks++; if (dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_dec_instr: got %08h, expected 00000013", dec_instr); end
    endtask

    task automatic test_latency();
        sb_q.push_back({CU_ADDI, 5'd1});
        send(enc_addi(5'd1));                 // accepted at edge 0
        tick(); tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL lat_early: issue_valid=%0b at edge 2, expected 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL lat_issue: issue_valid=%0b at edge 3, expected 1", issue_valid); end
        checks++; if (issue_rd !== 5'd1) begin errors++; $display("FAIL lat_rd: got %0d, expected 1", issue_rd); end
        tick();
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL lat_inflight: got %0d, expected 1", inflight_cnt); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL lat_back_idle: fetch_ready=%0b, expected 1", fetch_ready); end
    endtask

    task automatic test_raw();
        sb_q.push_back({CU_ADD, 5'd2});
        send(enc_add(5'd2, 5'd1, 5'd3));
        repeat (5) tick();
        checks++; if ({stall, issue_valid} !== 2'b10) begin errors++; $display("FAIL raw_stall: got stall=%0b valid=%0b, expected 1/0", stall, issue_valid); end
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_bypass: stall=%0b with wb x1, expected 0", stall); end
        tick();
        wb_valid = 1'b0; wb_rd = 5'd0;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL raw_issue: issue_valid=%0b, expected 1", issue_valid); end
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL raw_wb_dec: inflight=%0d, expected 0", inflight_cnt); end
        wait_issued();
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL raw_after: inflight=%0d, expected 1", inflight_cnt); end
        wb(5'd2);
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL raw_drain: inflight=%0d, expected 0", inflight_cnt); end
    endtask

    task automatic test_inflight_limit();
        for (int r = 1; r <= 4; r++) begin
            sb_q.push_back({CU_ADDI, 5'(r)});
            send(enc_addi(5'(r)));
            wait_issued();
        end
        checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL lim_full: inflight=%0d, expected 4", inflight_cnt); end
        sb_q.push_back({CU_ADDI, 5'd5});
        send(enc_addi(5'd5));
        repeat (6) tick();
        checks++; if ({stall, issue_valid} !== 2'b10) begin errors++; $display("FAIL lim_stall: got stall=%0b valid=%0b, expected 1/0", stall, issue_valid); end
        wb(5'd1);
        checks++; if (inflight_cnt !== 3'd3) begin errors++; $display("FAIL lim_wb: inflight=%0d, expected 3", inflight_cnt); end
        wait_issued();
        checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL lim_refill: inflight=%0d, expected 4", inflight_cnt); end
        for (int r = 2; r <= 5; r++) wb(5'(r));
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL lim_empty: inflight=%0d, expected 0", inflight_cnt); end
    endtask

    task automatic test_drain_trap();
        int traps = 0;
        int valids = 0;
        sb_q.push_back({CU_ADDI, 5'd7});
        send(enc_addi(5'd7));
        wait_issued();
        sb_q.push_back({6'd39, 5'd0});
        send(ECALL);
        repeat (6) tick();
        checks++; if ({stall, issue_valid} !== 2'b10) begin errors++; $display("FAIL drain_stall: got stall=%0b valid=%0b, expected 1/0", stall, issue_valid); end
        wb(5'd7);
        wait_issued();
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL drain_inflight: got %0d, expected 0", inflight_cnt); end
        send(ILLEGAL);
        for (int i = 0; i < 8; i++) begin
            if (illegal_trap) traps++;
            if (issue_valid) valids++;
            tick();
        end
        $display("trap: pulses=%0d valid_cycles=%0d", traps, valids);
        checks++; if (traps !== 1) begin errors++; $display("FAIL trap_pulse: got %0d cycles, expected 1", traps); end
        checks++; if (valids !== 0) begin errors++; $display("FAIL trap_no_issue: got %0d valid cycles, expected 0", valids); end
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL trap_sb: inflight=%0d, expected 0", inflight_cnt); end
    endtask

    task automatic test_flush();
        sb_q.push_back({CU_ADDI, 5'd8});
        send(enc_addi(5'd8));
        wait_issued();
        send(enc_add(5'd9, 5'd8, 5'd0));      // discarded by flush: nothing queued
        repeat (5) tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %0b, expected 1", stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if ({fetch_ready, stall, issue_valid} !== 3'b100) begin errors++; $display("FAIL flush_idle: got ready=%0b stall=%0b valid=%0b, expected 1/0/0", fetch_ready, stall, issue_valid); end
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL flush_keep: inflight=%0d, expected 1", inflight_cnt); end
        repeat (5) tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: issue_valid=%0b, expected 0", issue_valid); end
        wb(5'd8);
        issue_ready = 1'b0;
        sb_q.push_back({CU_ADDI, 5'd10});
        send(enc_addi(5'd10));
        wait_valid();
        flush = 1'b1; issue_ready = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if ({fetch_ready, issue_valid} !== 2'b10) begin errors++; $display("FAIL flush_hs_idle: got ready=%0b valid=%0b, expected 1/0", fetch_ready, issue_valid); end
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL flush_hs_sb: inflight=%0d, expected 1", inflight_cnt); end
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL flush_hs_issued: %0d ops pending, expected 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid_and_wb_edge();
        issue_ready = 1'b0;
        send(enc_addi(5'd11));                // lost to reset: nothing queued
        wait_valid();
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL rmid_pre: inflight=%0d, expected 1", inflight_cnt); end
        reset_n = 1'b0;
        #1;
        checks++; if ({issue_valid, inflight_cnt} !== 4'b0000) begin errors++; $display("FAIL rmid_clear: valid=%0b inflight=%0d, expected 0/0", issue_valid, inflight_cnt); end
        checks++; if (dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL rmid_nop: got %08h, expected 00000013", dec_instr); end
        tick();
        reset_n = 1'b1;
        issue_ready = 1'b1;
        tick();
        wb(5'd0);
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL wb_x0_empty: inflight=%0d, expected 0", inflight_cnt); end
        sb_q.push_back({CU_ADDI, 5'd12});
        send(enc_addi(5'd12));
        wait_issued();
        wb(5'd13);
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL wb_clear_reg: inflight=%0d, expected 1", inflight_cnt); end
        wb(5'd0);
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL wb_x0: inflight=%0d, expected 1", inflight_cnt); end
        wb(5'd12);
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL wb_final: inflight=%0d, expected 0", inflight_cnt); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_raw();
        test_inflight_limit();
        test_drain_trap();
        test_flush();
        test_reset_mid_and_wb_edge();
        repeat (3) tick();
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_leftover: %0d ops never issued, expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
